// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_AW   = 2;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned NUM_REGS = 2 ** DEF_AW;

  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, claim port.
interface regfile_sb_if #(
  parameter int unsigned AW = regfile_pkg::DEF_AW,
  parameter int unsigned DW = regfile_pkg::DEF_DW
) ();

  logic            rd_en1;
  logic [AW-1:0]   rd_addr1;
  logic            rd_prep1;
  logic            rd_en2;
  logic [AW-1:0]   rd_addr2;
  logic [DW-1:0]   rd_data1;
  logic [DW-1:0]   rd_data2;
  logic            rd_busy1;
  logic            rd_busy2;
  logic            stall;
  logic            wr_en;
  logic            wr_prep;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            claim_en;
  logic [AW-1:0]   claim_addr;
  logic            claim_grant;
  logic [2**AW-1:0] busy_vec;

  modport slave (
    input  rd_en1, rd_addr1, rd_prep1, rd_en2, rd_addr2,
    input  wr_en, wr_prep, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, stall, claim_grant, busy_vec
  );

  modport master (
    output rd_en1, rd_addr1, rd_prep1, rd_en2, rd_addr2,
    output wr_en, wr_prep, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, stall, claim_grant, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by a granted claim, cleared by a retiring write.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int unsigned AW = DEF_AW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           claim_en_i,
  input  logic [AW-1:0]  claim_addr_i,
  input  logic           retire_en_i,
  input  logic [AW-1:0]  retire_addr_i,
  input  logic [AW-1:0]  rd_addr1_i,
  input  logic [AW-1:0]  rd_addr2_i,
  output logic           claim_grant_o,
  output logic           busy1_o,
  output logic           busy2_o,
  output logic [2**AW-1:0] busy_vec_o
);

  localparam int unsigned N = 2 ** AW;

  logic [N-1:0] busy_q, busy_d;
  logic         retire_hit;

  assign retire_hit    = retire_en_i & (retire_addr_i == claim_addr_i);
  assign claim_grant_o = claim_en_i & ~reset & (~busy_q[claim_addr_i] | retire_hit);

  // Claim is applied after retire so a same-address claim leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (retire_en_i) busy_d[retire_addr_i] = 1'b0;
    if (claim_grant_o) busy_d[claim_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy1_o    = busy_q[rd_addr1_i];
  assign busy2_o    = busy_q[rd_addr2_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with prep register, optional write bypass and a claim/retire scoreboard.
module regfile_sb import regfile_pkg::*; #(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          PREP_EN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int unsigned N = 2 ** AW;

  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] prep_q;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          wp, rp, retire_en, rh1, rh2;
  logic          raw_busy1, raw_busy2, busy1, busy2, grant;
  logic [N-1:0]  busy_vec;

  assign wp        = bus.wr_prep & PREP_EN;
  assign rp        = bus.rd_prep1 & PREP_EN;
  assign retire_en = bus.wr_en & ~wp;
  assign rh1       = retire_en & (bus.wr_addr == bus.rd_addr1);
  assign rh2       = retire_en & (bus.wr_addr == bus.rd_addr2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
    end else if (retire_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  if (PREP_EN) begin : g_prep
    always_ff @(posedge clk) begin
      if (reset)                   prep_q <= '0;
      else if (bus.wr_en && wp)    prep_q <= bus.wr_data;
    end
  end else begin : g_no_prep
    assign prep_q = '0;
  end

  regfile_scoreboard #(
    .AW (AW)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .claim_en_i    (bus.claim_en),
    .claim_addr_i  (bus.claim_addr),
    .retire_en_i   (retire_en),
    .retire_addr_i (bus.wr_addr),
    .rd_addr1_i    (bus.rd_addr1),
    .rd_addr2_i    (bus.rd_addr2),
    .claim_grant_o (grant),
    .busy1_o       (raw_busy1),
    .busy2_o       (raw_busy2),
    .busy_vec_o    (busy_vec)
  );

  always_comb begin
    rd_data1 = rp ? prep_q : regs_q[bus.rd_addr1];
    if (BYPASS && ((rp && bus.wr_en && wp) || (!rp && rh1))) rd_data1 = bus.wr_data;
    rd_data2 = regs_q[bus.rd_addr2];
    if (BYPASS && rh2) rd_data2 = bus.wr_data;
  end

  // A forwarded retire satisfies the reader, so it no longer counts as pending.
  assign busy1 = ~rp & raw_busy1 & ~(BYPASS & rh1);
  assign busy2 = raw_busy2 & ~(BYPASS & rh2);

  assign bus.rd_data1    = rd_data1;
  assign bus.rd_data2    = rd_data2;
  assign bus.rd_busy1    = busy1;
  assign bus.rd_busy2    = busy2;
  assign bus.stall       = (bus.rd_en1 & busy1) | (bus.rd_en2 & busy2);
  assign bus.claim_grant = grant;
  assign bus.busy_vec    = busy_vec;

endmodule
